csi_tx_packetizer: RTL

- 2-lane MIPI CSI-2 byte-level packet transmitter: the transmit-side counterpart of csi_rx_top.
- Turns packet requests plus a payload stream into per-lane HS byte streams. Each packet is sync byte, header with ECC, payload, CRC-16, then trail.
- Use: camera-less loopback into csi_rx_top, and the basis of a future CSI TX bridge.
- Runs in the byte-clock domain; lane serialisation is outside this block.

---
 rtl/csi_tx_packetizer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/csi_tx_packetizer.sv
// 2-lane CSI-2 byte-level packet transmitter: sync, header+ECC, payload, CRC-16, trail.
// Byte-clock domain; per-lane bytes on tx_data[7:0] (lane 0) and tx_data[15:8] (lane 1).
module csi_tx_packetizer #(
    parameter int unsigned GAP_CYCLES = 8,
    parameter logic [7:0]  SYNC_BYTE  = 8'hB8
) (
    input  logic        clk,
    input  logic        areset_n,
    input  logic        pkt_req,
    output logic        pkt_ack,
    input  logic [1:0]  pkt_vc,
    input  logic [5:0]  pkt_dt,
    input  logic [15:0] pkt_wc,
    input  logic [15:0] pay_data,
    input  logic        pay_valid,
    output logic        pay_ready,
    output logic [15:0] tx_data,
    output logic        tx_hs_active,
    output logic        busy,
    input  logic        err_clr,
    output logic        err_underrun,
    output logic        err_odd_wc
);
    // state   | meaning
    // IDLE    | waiting for pkt_req
    // SYNC    | leader byte on both lanes
    // HDR0    | DI on lane 0, wc[7:0] on lane 1
    // HDR1    | wc[15:8] on lane 0, ECC on lane 1
    // PAYLOAD | payload beats, pay_data passed straight through
    // CRC     | CRC-16 bytes
    // TRAIL   | inverted bit7 of each lane's previous byte
    // GAP     | LP gap before the next request
    typedef enum logic [2:0] {IDLE, SYNC, HDR0, HDR1, PAYLOAD, CRC, TRAIL, GAP} state_t;

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t        state;
    logic [1:0]    vc_q;
    logic [5:0]    dt_q;
    logic [15:0]   wc_q;
    logic [14:0]   beat_cnt;
    logic [GW-1:0] gap_cnt;
    logic [15:0]   crc;
    logic [15:0]   tx_q;
    logic          hs_q;

    logic [7:0]    di;
    logic          long_pkt;
    logic          req_odd;
    logic [15:0]   beat_data;
    logic [15:0]   crc_upd;
    logic [15:0]   trail_data;

    function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] b);
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ b[i];
            c  = {fb, c[15:1]} ^ {5'b0, fb, 6'b0, fb, 3'b0};
        end
        return c;
    endfunction

    function automatic logic [5:0] ecc6(input logic [23:0] d);
        logic [5:0] p;
        p[0] = ^(d & 24'hF12CB7);
        p[1] = ^(d & 24'hF2555B);
        p[2] = ^(d & 24'h749A6D);
        p[3] = ^(d & 24'hB8E38E);
        p[4] = ^(d & 24'hDF03F0);
        p[5] = ^(d & 24'hEFFC00);
        return p;
    endfunction

    assign di         = {vc_q, dt_q};
    assign long_pkt   = (dt_q[5:4] != 2'b00);
    assign req_odd    = (pkt_dt[5:4] != 2'b00) && pkt_wc[0];
    assign beat_data  = pay_valid ? pay_data : 16'h0000;
    assign crc_upd    = crc_byte(crc_byte(crc, beat_data[7:0]), beat_data[15:8]);
    assign trail_data = {tx_data[15] ? 8'h00 : 8'hFF, tx_data[7] ? 8'h00 : 8'hFF};

    // HS cannot stall, so payload bypasses the output register to keep pay_ready same-cycle
    assign pkt_ack      = areset_n && (state == IDLE) && pkt_req;
    assign pay_ready    = (state == PAYLOAD);
    assign busy         = (state != IDLE);
    assign tx_hs_active = hs_q;
    assign tx_data      = (state == PAYLOAD) ? beat_data : tx_q;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state    <= IDLE;
            vc_q     <= '0;
            dt_q     <= '0;
            wc_q     <= '0;
            beat_cnt <= '0;
            gap_cnt  <= '0;
            crc      <= 16'hFFFF;
            tx_q     <= '0;
            hs_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pkt_ack) begin
                        vc_q <= pkt_vc;
                        dt_q <= pkt_dt;
                        wc_q <= pkt_wc;
                        crc  <= 16'hFFFF;
                        if (!req_odd) begin
                            state <= SYNC;
                            hs_q  <= 1'b1;
                            tx_q  <= {SYNC_BYTE, SYNC_BYTE};
                        end
                    end
                end
                SYNC: begin
                    state <= HDR0;
                    tx_q  <= {wc_q[7:0], di};
                end
                HDR0: begin
                    state <= HDR1;
                    tx_q  <= {2'b00, ecc6({wc_q, di}), wc_q[15:8]};
                end
                HDR1: begin
                    if (!long_pkt) begin
                        state <= TRAIL;
                        tx_q  <= trail_data;
                    end else if (wc_q[15:1] == 15'd0) begin
                        state <= CRC;
                        tx_q  <= crc;
                    end else begin
                        state    <= PAYLOAD;
                        beat_cnt <= wc_q[15:1] - 15'd1;
                        tx_q     <= '0;
                    end
                end
                PAYLOAD: begin
                    crc <= crc_upd;
                    if (beat_cnt == 15'd0) begin
                        state <= CRC;
                        tx_q  <= crc_upd;
                    end else begin
                        beat_cnt <= beat_cnt - 15'd1;
                    end
                end
                CRC: begin
                    state <= TRAIL;
                    tx_q  <= trail_data;
                end
                TRAIL: begin
                    state   <= GAP;
                    hs_q    <= 1'b0;
                    tx_q    <= '0;
                    gap_cnt <= GW'(GAP_CYCLES - 1);
                end
                GAP: begin
                    if (gap_cnt == '0) state <= IDLE;
                    else               gap_cnt <= gap_cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            err_underrun <= 1'b0;
            err_odd_wc   <= 1'b0;
        end else if (err_clr) begin
            err_underrun <= 1'b0;
            err_odd_wc   <= 1'b0;
        end else begin
            if ((state == PAYLOAD) && !pay_valid) err_underrun <= 1'b1;
            if (pkt_ack && req_odd)               err_odd_wc   <= 1'b1;
        end
    end

endmodule
